// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, ALU ops,
// opcodes and datapath select values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADR    = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXECUTE_R = 4'd6,
    EXECUTE_I = 4'd7,
    ALUWB     = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BR:   return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// funct3/funct7b5 to ALU operation decode for R- and I-type arithmetic,
// flagging encodings the ALU does not implement (slt*, sra*, odd f7 uses).
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       isRtype,
  output logic [2:0] aluControl,
  output logic       legal
);

  // For I-type, bit 30 is immediate data except on shifts.
  logic f7_r;
  assign f7_r = isRtype & funct7b5;

  always_comb begin
    aluControl = ALU_ADD;
    legal      = 1'b1;
    case (funct3)
      3'b000: aluControl = f7_r ? ALU_SUB : ALU_ADD;
      3'b001: begin aluControl = ALU_SLL; legal = !funct7b5; end
      3'b100: begin aluControl = ALU_XOR; legal = !f7_r; end
      3'b101: begin aluControl = ALU_SRL; legal = !funct7b5; end
      3'b110: begin aluControl = ALU_OR;  legal = !f7_r; end
      3'b111: begin aluControl = ALU_AND; legal = !f7_r; end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute, resolves
// branches from ALU flags and counts retired instructions.
//
// state     | meaning
// FETCH     | read instr at PC, PC <- PC+4
// DECODE    | aluOut <- oldPC+imm, legality check
// MEMADR    | aluOut <- rs1+imm
// MEMREAD   | read data memory at aluOut
// MEMWB     | rd <- memData (lw retires)
// MEMWRITE  | write data memory at aluOut (sw retires)
// EXECUTE_R | rs1 op rs2
// EXECUTE_I | rs1 op imm
// ALUWB     | rd <- aluOut (R/I/jal retire)
// BRANCH    | compare rs1-rs2, PC <- target if taken (retires)
// JAL       | PC <- target, aluOut <- oldPC+4
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 sign,
  output logic                 pcWrite,
  output logic                 adrSrc,
  output logic                 memWrite,
  output logic                 irWrite,
  output logic [1:0]           resultSrc,
  output logic [1:0]           aluSrcA,
  output logic [1:0]           aluSrcB,
  output logic [2:0]           aluControl,
  output logic [1:0]           immSrc,
  output logic                 regWrite,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_t state, state_nxt;
  logic [2:0] dec_op;
  logic       dec_legal, is_rtype, taken;
  logic       pc_we, mem_we, ir_we, reg_we, ill_c;

  assign is_rtype = (opcode == OP_R);

  alu_decoder u_alu_decoder (
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .isRtype    (is_rtype),
    .aluControl (dec_op),
    .legal      (dec_legal)
  );

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = sign;
      3'b101:  taken = !sign;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_we      = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    ill_c      = 1'b0;
    adrSrc     = 1'b0;
    resultSrc  = RES_ALUOUT;
    aluSrcA    = SRCA_PC;
    aluSrcB    = SRCB_RS2;
    aluControl = ALU_ADD;
    case (state)
      FETCH: begin
        ir_we     = 1'b1;
        pc_we     = 1'b1;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALURESULT;
        state_nxt = DECODE;
      end
      DECODE: begin
        aluSrcA   = SRCA_OLDPC;
        aluSrcB   = SRCB_IMM;
        ill_c     = 1'b1;
        state_nxt = FETCH;
        case (opcode)
          OP_LW, OP_SW:
            if (funct3 == 3'b010) begin ill_c = 1'b0; state_nxt = MEMADR; end
          OP_R:
            if (dec_legal) begin ill_c = 1'b0; state_nxt = EXECUTE_R; end
          OP_I:
            if (dec_legal) begin ill_c = 1'b0; state_nxt = EXECUTE_I; end
          OP_BR:
            if (funct3 inside {3'b000, 3'b001, 3'b100, 3'b101}) begin
              ill_c = 1'b0; state_nxt = BRANCH;
            end
          OP_JAL: begin ill_c = 1'b0; state_nxt = JAL; end
          default: ;
        endcase
      end
      MEMADR: begin
        aluSrcA   = SRCA_RS1;
        aluSrcB   = SRCB_IMM;
        state_nxt = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrSrc    = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        resultSrc = RES_MEMDATA;
        reg_we    = 1'b1;
        state_nxt = FETCH;
      end
      MEMWRITE: begin
        adrSrc    = 1'b1;
        mem_we    = 1'b1;
        state_nxt = FETCH;
      end
      EXECUTE_R: begin
        aluSrcA    = SRCA_RS1;
        aluControl = dec_op;
        state_nxt  = ALUWB;
      end
      EXECUTE_I: begin
        aluSrcA    = SRCA_RS1;
        aluSrcB    = SRCB_IMM;
        aluControl = dec_op;
        state_nxt  = ALUWB;
      end
      ALUWB: begin
        reg_we    = 1'b1;
        state_nxt = FETCH;
      end
      BRANCH: begin
        aluSrcA    = SRCA_RS1;
        aluControl = ALU_SUB;
        pc_we      = taken;
        state_nxt  = FETCH;
      end
      JAL: begin
        aluSrcA   = SRCA_OLDPC;
        aluSrcB   = SRCB_FOUR;
        pc_we     = 1'b1;
        state_nxt = ALUWB;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Reset holds state at FETCH, whose enables are active; mask them here.
  assign pcWrite  = pc_we  & rst_n;
  assign memWrite = mem_we & rst_n;
  assign irWrite  = ir_we  & rst_n;
  assign regWrite = reg_we & rst_n;
  assign illegal  = ill_c  & rst_n;
  assign immSrc   = imm_sel(opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instret <= '0;
    else if (state inside {MEMWB, MEMWRITE, ALUWB, BRANCH})
      instret <= instret + INSTRET_W'(1);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and checks state, selects, enables and instret.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5, zero, sign;
  logic        pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
  logic [1:0]  resultSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0]  aluControl;
  logic [31:0] instret;

  int n_pass = 0;
  int n_total = 0;
  int exp_instret = 0;
  int mw_count;

  multicycle_controller #(.INSTRET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .sign(sign), .pcWrite(pcWrite),
    .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
    .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluControl(aluControl), .immSrc(immSrc), .regWrite(regWrite),
    .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_st(input string tag, input state_t exp);
    chk(tag, 32'(dut.state), 32'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic run_branch(input string tag, input logic [2:0] f3,
                            input logic z, input logic s, input logic exp_pc);
    set_instr(OP_BR, f3, 1'b0);
    zero = 1'b0; sign = 1'b0;
    chk_st({tag, "_fetch"}, FETCH);
    step();
    chk({tag, "_imm"}, 32'(immSrc), 32'(IMM_B));
    step();
    zero = z; sign = s;
    #1;
    chk_st({tag, "_st"}, BRANCH);
    chk({tag, "_alu"}, 32'(aluControl), 32'(ALU_SUB));
    chk({tag, "_pcw"}, 32'(pcWrite), 32'(exp_pc));
    step();
    exp_instret++;
    chk({tag, "_instret"}, instret, 32'(exp_instret));
  endtask

  initial begin
    rst_n = 1'b0;
    set_instr(OP_R, 3'b000, 1'b0);
    zero = 1'b0; sign = 1'b0;
    step(); step();
    chk_st("rst_state", FETCH);
    chk("rst_pcw", 32'(pcWrite), 0);
    chk("rst_irw", 32'(irWrite), 0);
    chk("rst_regw", 32'(regWrite), 0);
    chk("rst_instret", instret, 0);
    chk("rst_srcb", 32'(aluSrcB), 32'(SRCB_FOUR));
    rst_n = 1'b1;
    #1;

    // add x3,x1,x2
    chk_st("add_fetch", FETCH);
    chk("add_irw", 32'(irWrite), 1);
    chk("add_pcw", 32'(pcWrite), 1);
    chk("add_res", 32'(resultSrc), 32'(RES_ALURESULT));
    step();
    chk_st("add_dec", DECODE);
    chk("add_dec_a", 32'(aluSrcA), 32'(SRCA_OLDPC));
    chk("add_dec_b", 32'(aluSrcB), 32'(SRCB_IMM));
    chk("add_dec_regw", 32'(regWrite), 0);
    step();
    chk_st("add_ex", EXECUTE_R);
    chk("add_ex_alu", 32'(aluControl), 32'(ALU_ADD));
    chk("add_ex_a", 32'(aluSrcA), 32'(SRCA_RS1));
    chk("add_ex_regw", 32'(regWrite), 0);
    step();
    chk_st("add_wb", ALUWB);
    chk("add_wb_regw", 32'(regWrite), 1);
    step();
    exp_instret++;
    chk("add_instret", instret, 32'(exp_instret));

    // lw
    set_instr(OP_LW, 3'b010, 1'b0);
    step();
    chk("lw_imm", 32'(immSrc), 32'(IMM_I));
    step();
    chk_st("lw_madr", MEMADR);
    step();
    chk_st("lw_mrd", MEMREAD);
    chk("lw_adr", 32'(adrSrc), 1);
    chk("lw_mrd_regw", 32'(regWrite), 0);
    step();
    chk_st("lw_mwb", MEMWB);
    chk("lw_res", 32'(resultSrc), 32'(RES_MEMDATA));
    chk("lw_regw", 32'(regWrite), 1);
    step();
    exp_instret++;
    chk_st("lw_done", FETCH);

    // sw: count memWrite cycles across the whole instruction
    set_instr(OP_SW, 3'b010, 1'b0);
    mw_count = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) chk("sw_imm", 32'(immSrc), 32'(IMM_S));
      if (i == 3) begin
        chk_st("sw_mwr", MEMWRITE);
        chk("sw_adr", 32'(adrSrc), 1);
      end
      mw_count += int'(memWrite);
      step();
    end
    exp_instret++;
    chk("sw_mw_once", 32'(mw_count), 1);
    chk_st("sw_done", FETCH);
    chk("sw_instret", instret, 32'(exp_instret));

    run_branch("beq_t", 3'b000, 1'b1, 1'b0, 1'b1);
    run_branch("beq_n", 3'b000, 1'b0, 1'b0, 1'b0);
    run_branch("blt_t", 3'b100, 1'b0, 1'b1, 1'b1);
    run_branch("bge_n", 3'b101, 1'b0, 1'b1, 1'b0);
    run_branch("bne_t", 3'b001, 1'b0, 1'b0, 1'b1);

    // illegal branch funct3
    set_instr(OP_BR, 3'b010, 1'b0);
    step();
    chk("brill_pulse", 32'(illegal), 1);
    step();
    chk_st("brill_back", FETCH);
    chk("brill_instret", instret, 32'(exp_instret));

    // srli
    set_instr(OP_I, 3'b101, 1'b0);
    step(); step();
    chk_st("srli_ex", EXECUTE_I);
    chk("srli_alu", 32'(aluControl), 32'(ALU_SRL));
    chk("srli_b", 32'(aluSrcB), 32'(SRCB_IMM));
    step(); step();
    exp_instret++;
    chk("srli_instret", instret, 32'(exp_instret));

    // srai is unsupported
    set_instr(OP_I, 3'b101, 1'b1);
    chk("srai_fetch_ill", 32'(illegal), 0);
    step();
    chk("srai_pulse", 32'(illegal), 1);
    chk("srai_regw", 32'(regWrite), 0);
    step();
    chk_st("srai_back", FETCH);
    chk("srai_ill_low", 32'(illegal), 0);
    chk("srai_instret", instret, 32'(exp_instret));

    // sub, then xor with f7=1 (illegal)
    set_instr(OP_R, 3'b000, 1'b1);
    step(); step();
    chk("sub_alu", 32'(aluControl), 32'(ALU_SUB));
    step(); step();
    exp_instret++;
    set_instr(OP_R, 3'b100, 1'b1);
    step();
    chk("xorf7_pulse", 32'(illegal), 1);
    step();
    chk("xorf7_instret", instret, 32'(exp_instret));

    // addi with bit30 set is still ADD
    set_instr(OP_I, 3'b000, 1'b1);
    step(); step();
    chk("addi_alu", 32'(aluControl), 32'(ALU_ADD));
    step(); step();
    exp_instret++;

    // jal
    set_instr(OP_JAL, 3'b000, 1'b0);
    step();
    chk("jal_imm", 32'(immSrc), 32'(IMM_J));
    step();
    chk_st("jal_st", JAL);
    chk("jal_pcw", 32'(pcWrite), 1);
    chk("jal_a", 32'(aluSrcA), 32'(SRCA_OLDPC));
    chk("jal_b", 32'(aluSrcB), 32'(SRCB_FOUR));
    chk("jal_instret_hold", instret, 32'(exp_instret));
    step();
    chk_st("jal_wb", ALUWB);
    chk("jal_regw", 32'(regWrite), 1);
    step();
    exp_instret++;
    chk_st("jal_done", FETCH);
    chk("jal_instret", instret, 32'(exp_instret));

    // async reset in MEMWRITE
    set_instr(OP_SW, 3'b010, 1'b0);
    step(); step(); step();
    chk("rstmid_mw", 32'(memWrite), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_mw_low", 32'(memWrite), 0);
    chk_st("rstmid_state", FETCH);
    chk("rstmid_instret", instret, 0);
    chk("rstmid_pcw", 32'(pcWrite), 0);
    step();
    chk_st("rstmid_hold", FETCH);
    chk("rstmid_hold_mw", 32'(memWrite), 0);
    rst_n = 1'b1;
    #1;
    chk("resume_irw", 32'(irWrite), 1);
    step();
    chk_st("resume_dec", DECODE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
